// File: rtl/scrambler_frame_ctrl.sv
// rtl/scrambler_frame_ctrl.sv - frame sequencer for the x^7+x^4+1 scrambler datapath
// Optional feature macro: SCRAMBLER_TAIL_EN (adds 6-cycle TAIL state with zeroed tx_bit)
module scrambler_frame_ctrl #(
  parameter int LEN_W    = 12,
  parameter int SVC_BITS = 16,
  parameter int SCR_LAT  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             scr_reset,
  output logic             scr_enable,
  output logic             scr_bit_in,
  input  logic             scr_bit_out,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  localparam int TAIL_BITS = 6;
  // Shared counter for SERVICE bits and tail cycles; must hold both terminal counts.
  localparam int CNT_W = (SVC_BITS > 8) ? $clog2(SVC_BITS) : 3;

`ifdef SCRAMBLER_TAIL_EN
  typedef enum logic [2:0] {IDLE, SEED, SVC, DATA, TAIL, FIN} state_t;
  localparam state_t POST = TAIL;
`else
  typedef enum logic [2:0] {IDLE, SEED, SVC, DATA, FIN} state_t;
  localparam state_t POST = FIN;
`endif

  state_t             state, state_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [7:0]         shreg;
  logic [2:0]         idx;
  logic               loaded;
  logic [SCR_LAT-1:0] en_pipe;
  logic               accept;

  // A new byte may enter when the shift register is empty or draining its last bit.
  assign byte_ready = (state == DATA) && (byte_cnt != '0) && (!loaded || (idx == 3'd7));
  assign accept     = byte_valid & byte_ready;
  assign tx_valid   = en_pipe[SCR_LAT-1];
  assign busy       = (state != IDLE) && !done;

  // Next-state and per-state scrambler controls.
  always_comb begin
    state_nx   = state;
    scr_reset  = 1'b0;
    scr_enable = 1'b0;
    scr_bit_in = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SEED;
      end
      SEED: begin
        scr_reset = 1'b1;
        state_nx  = SVC;
      end
      SVC: begin
        scr_enable = 1'b1;
        if (bit_cnt == CNT_W'(SVC_BITS - 1)) state_nx = (byte_cnt == '0) ? POST : DATA;
      end
      DATA: begin
        if (loaded) begin
          scr_enable = 1'b1;
          scr_bit_in = shreg[idx];
          if ((idx == 3'd7) && (byte_cnt == '0) && !accept) state_nx = POST;
        end
      end
`ifdef SCRAMBLER_TAIL_EN
      TAIL: begin
        scr_enable = 1'b1;
        if (bit_cnt == CNT_W'(TAIL_BITS - 1)) state_nx = FIN;
      end
`endif
      FIN: begin
        if (en_pipe == '0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // SERVICE/tail cycle counter restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                bit_cnt <= '0;
    else if (state_nx != state)               bit_cnt <= '0;
`ifdef SCRAMBLER_TAIL_EN
    else if ((state == SVC) || (state == TAIL)) bit_cnt <= bit_cnt + 1'b1;
`else
    else if (state == SVC)                    bit_cnt <= bit_cnt + 1'b1;
`endif
  end

  // Remaining-byte counter: latched from length at start, decremented per accepted byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        byte_cnt <= '0;
    else if ((state == IDLE) && start) byte_cnt <= length;
    else if (accept)                  byte_cnt <= byte_cnt - 1'b1;
  end

  // Byte shift register: load on accept, step through bits LSB first on issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      idx    <= '0;
      loaded <= 1'b0;
    end else if (state != DATA) begin
      idx    <= '0;
      loaded <= 1'b0;
    end else if (accept) begin
      shreg  <= byte_data;
      idx    <= '0;
      loaded <= 1'b1;
    end else if (loaded) begin
      if (idx == 3'd7) loaded <= 1'b0;
      else             idx    <= idx + 3'd1;
    end
  end

  // Enable delay line matching the scrambler latency; drives tx_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= scr_enable;
      for (int i = 1; i < SCR_LAT; i++) en_pipe[i] <= en_pipe[i-1];
    end
  end

`ifdef SCRAMBLER_TAIL_EN
  logic [SCR_LAT-1:0] tail_pipe;

  // Marks which returning bits belong to tail cycles so they can be zeroed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tail_pipe <= '0;
    end else begin
      tail_pipe[0] <= (state == TAIL);
      for (int i = 1; i < SCR_LAT; i++) tail_pipe[i] <= tail_pipe[i-1];
    end
  end

  assign tx_bit = tail_pipe[SCR_LAT-1] ? 1'b0 : scr_bit_out;
`else
  assign tx_bit = scr_bit_out;
`endif

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// tb/tb_scrambler_frame_ctrl.sv - self-checking bench for scrambler_frame_ctrl
module tb_scrambler_frame_ctrl;

`ifdef SCRAMBLER_TAIL_EN
  localparam int TAIL = 6;
`else
  localparam int TAIL = 0;
`endif
  localparam int       SVC  = 16;
  localparam logic [6:0] SEED = 7'b1011101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] length = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, scr_reset, scr_enable, scr_bit_in, scr_bit_out;
  logic        tx_bit, tx_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  scrambler_frame_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .scr_reset(scr_reset), .scr_enable(scr_enable), .scr_bit_in(scr_bit_in),
    .scr_bit_out(scr_bit_out), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Additive scrambler with one cycle of latency, standing in for the real instance.
  logic [6:0] lfsr;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr        <= '0;
      scr_bit_out <= 1'b0;
    end else if (scr_reset) begin
      lfsr <= SEED;
    end else if (scr_enable) begin
      scr_bit_out <= scr_bit_in ^ lfsr[6] ^ lfsr[3];
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
    end
  end

  typedef struct {
    int          len;
    logic [63:0] data;
    int          stall;
    bit          glitch;
    int          exp_en;
    int          exp_gap;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [6:0] idle_outs();
    return {byte_ready, scr_reset, scr_enable, scr_bit_in, tx_valid, busy, done};
  endfunction

  task automatic run_frame(input vec_t v);
    bit   exp_in[$];
    bit   exp_tx[$];
    bit   got_in[$];
    bit   got_tx[$];
    logic [6:0] l;
    int   cyc = 0, k = 0, stall_left = 0, en_cnt = 0, gap = 0, seed_cnt = 0;
    int   seed_ok = 0, txv_cnt = 0, last_txv = -1, done_cnt = 0, done_cyc = -1;
    int   busy_cnt = 0, acc_on_en = 0, bad_in = 0, bad_tx = 0;
    bit   glitched = 0, busy_at_done = 0;
    int   data_end = SVC + 8 * v.len;
    // Expected bit stream: SERVICE zeros, PSDU LSB first, tail zeros.
    for (int i = 0; i < SVC; i++) exp_in.push_back(1'b0);
    for (int b = 0; b < v.len; b++)
      for (int i = 0; i < 8; i++) exp_in.push_back(v.data[8*b+i]);
    for (int i = 0; i < TAIL; i++) exp_in.push_back(1'b0);
    l = SEED;
    for (int n = 0; n < exp_in.size(); n++) begin
      exp_tx.push_back((n >= data_end) ? 1'b0 : (exp_in[n] ^ l[6] ^ l[3]));
      l = {l[5:0], l[6] ^ l[3]};
    end
    while (cyc < 2000 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      @(posedge clock); #1;
      start  = (cyc == 0);
      length = 12'(v.len);
      if (v.glitch && !glitched && en_cnt >= 20) begin
        start    = 1'b1;
        length   = 12'd9;
        glitched = 1;
      end
      byte_valid = (k < v.len) && (stall_left == 0);
      byte_data  = byte_valid ? v.data[8*k +: 8] : 8'($urandom);
      #1;
      if (byte_valid && byte_ready) begin
        if (scr_enable) acc_on_en++;
        k++;
        stall_left = v.stall;
      end else if (byte_ready && stall_left > 0) begin
        stall_left--;
      end
      if (scr_reset) begin
        seed_cnt++;
        if (en_cnt == 0) seed_ok = 1;
      end
      if (scr_enable) begin
        got_in.push_back(scr_bit_in);
        en_cnt++;
      end else if (en_cnt > SVC && en_cnt < data_end) begin
        gap++;
      end
      if (tx_valid) begin
        got_tx.push_back(tx_bit);
        txv_cnt++;
        last_txv = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      cyc++;
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    if (done_cnt == 0) check("timeout", cyc, 0);
    for (int i = 0; i < exp_in.size() && i < got_in.size(); i++)
      if (got_in[i] != exp_in[i]) bad_in++;
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      if (got_tx[i] != exp_tx[i]) bad_tx++;
    check("seed_pulses", seed_cnt, 1);
    check("seed_before_enable", seed_ok, 1);
    check("enable_count", en_cnt, v.exp_en);
    check("bit_in_errors", bad_in, 0);
    check("tx_valid_count", txv_cnt, v.exp_en);
    check("tx_bit_errors", bad_tx, 0);
    check("data_stall_cycles", gap, v.exp_gap);
    check("ready_on_last_bit", acc_on_en, (v.stall == 0 && v.len > 0) ? v.len - 1 : 0);
    check("done_pulses", done_cnt, 1);
    check("done_after_last_tx", done_cyc, last_txv + 1);
    check("busy_at_done", busy_at_done, 0);
    check("busy_cycles", busy_cnt, done_cyc - 1);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    tbl[0] = '{1, 64'hA5,               0, 0, 16 + 8 + TAIL,  0};
    tbl[1] = '{0, 64'h0,                0, 0, 16 + TAIL,      0};
    tbl[2] = '{3, 64'h80FF01,           0, 0, 16 + 24 + TAIL, 0};
    tbl[3] = '{2, 64'h3C5A,             3, 0, 16 + 16 + TAIL, 3};
    tbl[4] = '{2, 64'hC3E7,             1, 1, 16 + 16 + TAIL, 1};
    tbl[5] = '{4, 64'h12345678,         2, 0, 16 + 32 + TAIL, 6};

    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", idle_outs(), 0);
    reset = 1'b0;
    @(posedge clock); #2;
    check("idle_outputs", idle_outs(), 0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset in the middle of DATA: outputs clear immediately and no done follows.
    begin
      int en_cnt = 0;
      int cyc = 0;
      int stray = 0;
      while (en_cnt < 24 && cyc < 200) begin
        @(posedge clock); #1;
        start      = (cyc == 0);
        length     = 12'd4;
        byte_valid = 1'b1;
        byte_data  = 8'h6D;
        #1;
        if (scr_enable) en_cnt++;
        cyc++;
      end
      check("reached_data", en_cnt, 24);
      start = 1'b0;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", idle_outs(), 0);
      @(posedge clock); #2;
      check("reset_next_cycle", idle_outs(), 0);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clock); #2;
        if (done || busy || scr_enable || tx_valid) stray++;
      end
      check("no_activity_after_reset", stray, 0);
      byte_valid = 1'b0;
    end

    for (int r = 0; r < 8; r++) begin
      rv.len     = $urandom_range(0, 5);
      rv.data    = {$urandom, $urandom};
      rv.stall   = $urandom_range(0, 3);
      rv.glitch  = 1'($urandom_range(0, 1));
      rv.exp_en  = SVC + 8 * rv.len + TAIL;
      rv.exp_gap = (rv.len > 0) ? (rv.len - 1) * rv.stall : 0;
      run_frame(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
